// File: rtl/enemy_spawn_sequencer_if.sv
// Spawn hand-off bus between the spawn sequencer and the enemy management logic.
// Ports: spawn_valid/spawn_x/spawn_y driven by the master, spawn_ready by the slave.
// A transfer happens on a rising clock edge with spawn_valid && spawn_ready.
interface enemy_spawn_sequencer_if;
  logic        spawn_valid;
  logic        spawn_ready;
  logic [11:0] spawn_x;
  logic [11:0] spawn_y;

  modport master (
    output spawn_valid,
    output spawn_x,
    output spawn_y,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid,
    input  spawn_x,
    input  spawn_y,
    output spawn_ready
  );
endinterface

// File: rtl/enemy_spawn_sequencer.sv
// Purpose: walks one level's spawn table in the 12-bit level ROM and presents
//   each (x, y) entry to the enemy management logic, pacing entries by frames.
// Latency: level_start in cycle N -> READ_X in N+1, spawn_valid in N+4; after a
//   transfer the next fetch starts once GAP_FRAMES frame ticks have been counted.
// Backpressure: spawn_valid/spawn_x/spawn_y hold until spawn_ready; only
//   level_start or rst can withdraw a pending spawn.
// Ports: clk, rst (async, active-high); level_start/level start a walk;
//   frame_tick paces gaps; rom_addr/rom_data read the synchronous ROM;
//   spawn (master modport) carries spawn_valid/ready/x/y; busy/done report status.
// Option: define ENEMY_SPAWN_LOOP_EN to replay the table continuously instead
//   of stopping in DONE (an empty table still ends in DONE).
module enemy_spawn_sequencer #(
  parameter int GAP_FRAMES = 60,
  parameter int GAP_W      = 8    // GAP_FRAMES must fit in GAP_W bits
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           level_start,
  input  logic [2:0]                     level,
  input  logic                           frame_tick,
  output logic [6:0]                     rom_addr,
  input  logic [11:0]                    rom_data,
  enemy_spawn_sequencer_if.master        spawn,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [2:0] {
    IDLE,
    READ_X,
    READ_Y,
    LATCH_Y,
    PRESENT,
    WAIT_GAP,
    DONE
  } state_t;

  localparam logic [11:0]      TERMINATOR = 12'hFFF;
  localparam logic [GAP_W-1:0] GAP_END    = GAP_W'(GAP_FRAMES);
  localparam logic [GAP_W:0]   GAP_END_X  = (GAP_W+1)'(GAP_FRAMES);

  state_t           state, state_nxt;
  logic [2:0]       level_q, level_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic [6:0]       addr_nxt;
  logic [11:0]      spawn_x_q, x_nxt;
  logic [11:0]      spawn_y_q, y_nxt;

  // One extra bit so the increment can be compared without wrapping.
  logic [GAP_W:0]   gap_inc;
  logic             gap_elapsed;

  assign gap_inc = {1'b0, gap_cnt} + {{GAP_W{1'b0}}, 1'b1};

  // The gap ends either when the count already sits at the limit (covers a
  // zero-frame gap) or on the tick that brings it there.
  assign gap_elapsed = (gap_cnt == GAP_END) || (frame_tick && (gap_inc == GAP_END_X));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers, all updated from the next-state logic below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= 3'd0;
      idx       <= 3'd0;
      gap_cnt   <= '0;
      rom_addr  <= 7'd0;
      spawn_x_q <= 12'd0;
      spawn_y_q <= 12'd0;
    end else begin
      level_q   <= level_nxt;
      idx       <= idx_nxt;
      gap_cnt   <= gap_nxt;
      rom_addr  <= addr_nxt;
      spawn_x_q <= x_nxt;
      spawn_y_q <= y_nxt;
    end
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_nxt = state;
    level_nxt = level_q;
    idx_nxt   = idx;
    gap_nxt   = gap_cnt;
    addr_nxt  = rom_addr;
    x_nxt     = spawn_x_q;
    y_nxt     = spawn_y_q;

    if (level_start) begin
      // A restart wins over everything, including a same-cycle transfer, so
      // the aborted entry never advances idx.
      level_nxt = level;
      idx_nxt   = 3'd0;
      gap_nxt   = '0;
      addr_nxt  = {level, 3'd0, 1'b0};
      state_nxt = READ_X;
    end else begin
      case (state)
        IDLE, DONE: begin
          state_nxt = state;
        end

        READ_X: begin
          // x word address is on the ROM now; queue the y word behind it.
          addr_nxt  = {level_q, idx, 1'b1};
          state_nxt = READ_Y;
        end

        READ_Y: begin
          if (rom_data == TERMINATOR) begin
`ifdef ENEMY_SPAWN_LOOP_EN
            // An empty table would otherwise spin forever without spawning.
            if (idx == 3'd0) begin
              state_nxt = DONE;
            end else begin
              idx_nxt   = 3'd0;
              gap_nxt   = '0;
              state_nxt = WAIT_GAP;
            end
`else
            state_nxt = DONE;
`endif
          end else begin
            x_nxt     = rom_data;
            state_nxt = LATCH_Y;
          end
        end

        LATCH_Y: begin
          y_nxt     = rom_data;
          state_nxt = PRESENT;
        end

        PRESENT: begin
          if (spawn.spawn_ready) begin
            // idx wraps to 0 after entry 7; that only matters in loop mode.
            idx_nxt = idx + 3'd1;
            gap_nxt = '0;
`ifdef ENEMY_SPAWN_LOOP_EN
            state_nxt = WAIT_GAP;
`else
            state_nxt = (idx == 3'd7) ? DONE : WAIT_GAP;
`endif
          end
        end

        WAIT_GAP: begin
          if (gap_elapsed) begin
            addr_nxt  = {level_q, idx, 1'b0};
            state_nxt = READ_X;
          end else if (frame_tick) begin
            gap_nxt = gap_inc[GAP_W-1:0];
          end
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign spawn.spawn_valid = (state == PRESENT);
  assign spawn.spawn_x     = spawn_x_q;
  assign spawn.spawn_y     = spawn_y_q;
  assign busy              = (state != IDLE) && (state != DONE);
  assign done              = (state == DONE);

endmodule

// File: tb/tb_enemy_spawn_sequencer.sv
// Bench for enemy_spawn_sequencer: directed level walks against a table-driven
// model of the expected spawn stream, plus hand-computed timing and address checks.
module tb_enemy_spawn_sequencer;

  localparam int GAP = 2;

  logic        clk;
  logic        rst;
  logic        level_start;
  logic [2:0]  level;
  logic        frame_tick;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic        busy;
  logic        done;

  enemy_spawn_sequencer_if sif ();

  enemy_spawn_sequencer #(.GAP_FRAMES(GAP), .GAP_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .level_start (level_start),
    .level       (level),
    .frame_tick  (frame_tick),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .spawn       (sif),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous level ROM.
  logic [11:0] rom [128];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // ---------------- model: expected spawn stream per level ----------------
  typedef logic [23:0] pair_t;
  pair_t       exp_q[$];
  int          m_errs = 0;
  int          m_checks = 0;
  int          xfers = 0;
  logic        hold_prev = 1'b0;
  logic        done_prev = 1'b0;
  logic [11:0] hx = 12'd0;
  logic [11:0] hy = 12'd0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
      done_prev = 1'b0;
    end else if (level_start) begin
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
        if (rom[{level, i[2:0], 1'b0}] == 12'hFFF) break;
        exp_q.push_back({rom[{level, i[2:0], 1'b0}], rom[{level, i[2:0], 1'b1}]});
      end
`ifdef ENEMY_SPAWN_LOOP_EN
      if (exp_q.size() > 0) begin
        int n;
        n = exp_q.size();
        repeat (3) for (int j = 0; j < n; j++) exp_q.push_back(exp_q[j]);
      end
`endif
      hold_prev = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (sif.spawn_valid) begin
        m_checks++;
        if (exp_q.size() == 0) begin
          m_errs++;
          $display("FAIL spawn_data: got %h,%h required no pending spawn", sif.spawn_x, sif.spawn_y);
        end else if ({sif.spawn_x, sif.spawn_y} !== exp_q[0]) begin
          m_errs++;
          $display("FAIL spawn_data: got %h,%h required %h,%h", sif.spawn_x, sif.spawn_y,
                   exp_q[0][23:12], exp_q[0][11:0]);
        end
      end
      if (hold_prev) begin
        m_checks++;
        if (!sif.spawn_valid || sif.spawn_x !== hx || sif.spawn_y !== hy) begin
          m_errs++;
          $display("FAIL spawn_hold: got v=%b %h,%h required v=1 %h,%h",
                   sif.spawn_valid, sif.spawn_x, sif.spawn_y, hx, hy);
        end
      end
      if (done && !done_prev) begin
        m_checks++;
        if (exp_q.size() != 0 || busy || sif.spawn_valid) begin
          m_errs++;
          $display("FAIL done_state: got pending=%0d busy=%b valid=%b required 0 0 0",
                   exp_q.size(), busy, sif.spawn_valid);
        end
      end
      if (sif.spawn_valid && sif.spawn_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        xfers++;
      end
      hold_prev = sif.spawn_valid && !sif.spawn_ready;
      hx = sif.spawn_x;
      hy = sif.spawn_y;
      done_prev = done;
    end
  end

  // ROM address trace per walk (distinct consecutive values).
  logic [6:0] addr_log[$];
  logic [7:0] last_addr = 8'hFF;
  logic [6:0] max_addr = 7'd0;
  always @(negedge clk) begin
    if (level_start) begin
      addr_log.delete();
      last_addr = 8'hFF;
      max_addr = 7'd0;
    end else if (!rst && {1'b0, rom_addr} != last_addr) begin
      addr_log.push_back(rom_addr);
      last_addr = {1'b0, rom_addr};
      if (rom_addr > max_addr) max_addr = rom_addr;
    end
  end

  // ---------------- directed stimulus ----------------
  int errs = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic start(input logic [2:0] lv);
    level = lv;
    level_start = 1'b1;
    @(posedge clk); #1;
    level_start = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!sif.spawn_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic count_valid(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (sif.spawn_valid) cnt++;
    end
  endtask

  // Issues frame ticks until the next spawn or done appears (ready must be high
  // on entry if a spawn is pending, so the first edge completes it).
  task automatic next_spawn();
    int k;
    int w;
    k = 0;
    do begin
      tick();
      w = 0;
      while (!sif.spawn_valid && !done && w < 6) begin
        @(posedge clk); #1;
        w++;
      end
      k++;
    end while (!sif.spawn_valid && !done && k < 20);
  endtask

  initial begin
    int n;
    int cnt;
    int xf0;
    logic [63:0] seq;

    rst = 1'b1;
    level_start = 1'b0;
    level = 3'd0;
    frame_tick = 1'b0;
    sif.spawn_ready = 1'b0;

    for (int a = 0; a < 128; a++) rom[a] = 12'hFFF;
    // level 2: (10,20),(30,40), end
    rom[7'h20] = 12'd10;  rom[7'h21] = 12'd20;
    rom[7'h22] = 12'd30;  rom[7'h23] = 12'd40;
    // level 3: (100,200),(300,400), end
    rom[7'h30] = 12'd100; rom[7'h31] = 12'd200;
    rom[7'h32] = 12'd300; rom[7'h33] = 12'd400;
    // level 1: (7,8),(9,10), end
    rom[7'h10] = 12'd7;   rom[7'h11] = 12'd8;
    rom[7'h12] = 12'd9;   rom[7'h13] = 12'd10;
    // level 5: (500,600), end
    rom[7'h50] = 12'd500; rom[7'h51] = 12'd600;
    // level 4: (1,2),(3,4), end
    rom[7'h40] = 12'd1;   rom[7'h41] = 12'd2;
    rom[7'h42] = 12'd3;   rom[7'h43] = 12'd4;
    // level 6: eight entries, no terminator
    for (int e = 0; e < 8; e++) begin
      rom[{3'd6, e[2:0], 1'b0}] = 12'h600 + 12'(e);
      rom[{3'd6, e[2:0], 1'b1}] = 12'h700 + 12'(e);
    end
    // level 7 stays all FFF: empty table

    repeat (2) @(posedge clk);
    #1;
    check("reset_rom_addr", rom_addr, 0);
    check("reset_valid", sif.spawn_valid, 0);
    check("reset_x", sif.spawn_x, 0);
    check("reset_y", sif.spawn_y, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef ENEMY_SPAWN_LOOP_EN
    sif.spawn_ready = 1'b1;
    start(3'd4);
    wait_valid(n);
    check("loop_latency", n + 1, 4);
    check("loop_spawn0", {sif.spawn_x, sif.spawn_y}, {12'd1, 12'd2});
    for (int k = 1; k < 4; k++) begin
      next_spawn();
      check("loop_spawn", {sif.spawn_valid, sif.spawn_x, sif.spawn_y},
            (k % 2 == 1) ? {1'b1, 12'd3, 12'd4} : {1'b1, 12'd1, 12'd2});
      check("loop_no_done", done, 0);
    end
    start(3'd7);
    wait_done(n);
    check("empty_done_latency", n + 1, 3);
    check("empty_done", done, 1);
`else
    // ---- level 2 walk, ready high, gap of 2 frames ----
    sif.spawn_ready = 1'b1;
    xf0 = xfers;
    start(3'd2);
    wait_valid(n);
    check("first_latency", n + 1, 4);
    check("spawn0", {sif.spawn_x, sif.spawn_y}, {12'd10, 12'd20});
    // tick coincides with the transfer edge and must be ignored
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    count_valid(8, cnt);
    check("gap_no_tick", cnt, 0);
    tick();
    count_valid(8, cnt);
    check("gap_one_tick", cnt, 0);
    tick();
    wait_valid(n);
    check("gap_latency", n + 4, 4 + 3);
    check("spawn1", {sif.spawn_x, sif.spawn_y}, {12'd30, 12'd40});
    tick();
    tick();
    wait_done(n);
    check("done_latency", n + 1, 3);
    check("done_busy", {done, busy}, {1'b1, 1'b0});
    check("walk2_xfers", xfers - xf0, 2);
    seq = '0;
    if (addr_log.size() >= 5) seq = {29'd0, addr_log[0], addr_log[1], addr_log[2], addr_log[3], addr_log[4]};
    check("rom_addr_seq", seq, {29'd0, 7'h20, 7'h21, 7'h22, 7'h23, 7'h24});

    // ---- backpressure on level 3, then reset during the gap ----
    sif.spawn_ready = 1'b0;
    start(3'd3);
    wait_valid(n);
    check("bp_latency", n + 1, 4);
    repeat (50) begin
      @(posedge clk); #1;
    end
    check("bp_stable", {sif.spawn_valid, sif.spawn_x, sif.spawn_y}, {1'b1, 12'd100, 12'd200});
    xf0 = xfers;
    sif.spawn_ready = 1'b1;
    @(posedge clk); #1;
    sif.spawn_ready = 1'b0;
    check("bp_one_xfer", xfers - xf0, 1);
    check("bp_valid_drop", {sif.spawn_valid, busy}, {1'b0, 1'b1});
    tick();
    rst = 1'b1;
    #2;
    check("async_reset", {rom_addr, sif.spawn_valid, sif.spawn_x, sif.spawn_y, busy, done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    tick();
    tick();
    count_valid(10, cnt);
    check("stay_idle", {cnt[7:0], busy, done, rom_addr}, 0);

    // ---- full 8-entry table on level 6 ----
    sif.spawn_ready = 1'b1;
    xf0 = xfers;
    start(3'd6);
    wait_valid(n);
    check("full_first", {sif.spawn_x, sif.spawn_y}, {12'h600, 12'h700});
    for (int k = 0; k < 8 && !done; k++) next_spawn();
    check("full_xfers", xfers - xf0, 8);
    check("full_done", done, 1);
    check("full_max_addr", max_addr, 7'h6F);

    // ---- abort level 1 in PRESENT with a same-cycle ready ----
    sif.spawn_ready = 1'b0;
    start(3'd1);
    wait_valid(n);
    check("abort_first", {sif.spawn_x, sif.spawn_y}, {12'd7, 12'd8});
    xf0 = xfers;
    sif.spawn_ready = 1'b1;
    start(3'd5);
    sif.spawn_ready = 1'b0;
    check("abort_valid_drop", {sif.spawn_valid, busy}, {1'b0, 1'b1});
    wait_valid(n);
    check("abort_latency", n + 1, 4);
    check("abort_spawn", {sif.spawn_x, sif.spawn_y}, {12'd500, 12'd600});
    check("abort_addr", (addr_log.size() > 0) ? addr_log[0] : 7'h7F, 7'h50);
    sif.spawn_ready = 1'b1;
    next_spawn();
    check("abort_done", done, 1);
    check("abort_xfers", xfers - xf0, 1);
`endif

    @(negedge clk);
    @(posedge clk); #1;
    errs = errs + m_errs;
    checks = checks + m_checks;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/enemy_spawn_sequencer.md
# enemy_spawn_sequencer

Walks the per-level enemy spawn table stored in the shared 12-bit level ROM and hands spawn coordinates, one enemy at a time, to the enemy management logic over a valid/ready handshake. It is the reader side of the 12-bit ROM word stream that the enemy management unit consumes. It paces spawns in frames and reports when a level's table is exhausted.

## Interface
Parameters:
- GAP_FRAMES, 60: frame ticks between an accepted spawn and the next ROM fetch.
- GAP_W, 8: width of the gap counter; GAP_FRAMES must be < 2^GAP_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- level_start  in  1  one-cycle pulse that starts (or restarts) the table walk.
- level  in  3  level index; sampled only on level_start.
- frame_tick  in  1  one-cycle pulse per video frame.
- rom_addr  out  7  registered ROM address {level, idx[2:0], sel}; sel=0 selects the x word, sel=1 selects the y word.
- rom_data  in  12  synchronous ROM data, valid 1 cycle after rom_addr.
- spawn_valid  out  1  spawn_x/spawn_y hold a pending spawn.
- spawn_ready  in  1  consumer accepts the spawn.
- spawn_x, spawn_y  out  12  spawn coordinates, stable while spawn_valid=1.
- busy  out  1  walk in progress; high in every state except IDLE and DONE.
- done  out  1  table exhausted; held high until the next level_start.

## Operation
- Table layout: 16 words per level, up to 8 entries. Each entry is an x word followed by a y word. An x word of 12'hFFF terminates the table.
- State machine: IDLE, READ_X, READ_Y, LATCH_Y, PRESENT, WAIT_GAP, DONE.
- IDLE/DONE + level_start:
  - latch level
  - set idx=0 and done=0
  - set rom_addr={level,0,0}
  - go to READ_X. The first spawn has no gap.
- READ_X: the ROM is addressed. Set rom_addr sel=1 and go to READ_Y.
- READ_Y: rom_data is the x word.
  - If it equals 12'hFFF, go to DONE.
  - Otherwise latch spawn_x and go to LATCH_Y.
- LATCH_Y: latch spawn_y from rom_data, set spawn_valid=1, go to PRESENT.
- PRESENT: hold the outputs. On spawn_ready=1:
  - set spawn_valid=0
  - increment idx
  - clear the gap counter
  - go to WAIT_GAP, or to DONE if idx was 7.
- WAIT_GAP: count frame_tick pulses. At count GAP_FRAMES, set rom_addr={level,idx,0} and go to READ_X.
- DONE: done=1, busy=0, spawn_valid=0.
- spawn_x/spawn_y keep their last values after a handshake. They change only in READ_Y/LATCH_Y.

## Timing
- Reset values:
  - state IDLE
  - rom_addr 0
  - spawn_valid 0
  - spawn_x 0, spawn_y 0
  - busy 0, done 0
  - gap counter 0
- Latency: level_start in cycle N gives READ_X in N+1 and spawn_valid=1 in N+4.
- Handshake: a transfer occurs when spawn_valid && spawn_ready on a rising edge. spawn_ready while spawn_valid=0 is ignored. spawn_valid never drops without a transfer, except on level_start or rst.
- level_start in any state aborts the current walk:
  - spawn_valid drops the next cycle
  - the new level is latched
  - the walk restarts at READ_X
  - level_start takes priority over a simultaneous transfer; idx is not advanced.
- A frame_tick that coincides with the transfer cycle is not counted.
- GAP_FRAMES=0: WAIT_GAP exits on the first cycle without waiting for a tick.
- Index wrap: idx is 3 bits. A transfer at idx=7 goes to DONE; it never wraps into the next level's table.
- rst mid-operation returns to the reset values immediately, asynchronously.

## Configuration
- ENEMY_SPAWN_LOOP_EN:
  - Defined: the terminator, or a transfer at idx=7, resets idx to 0 and goes to WAIT_GAP instead of DONE, so the table respawns continuously. done is never asserted. A terminator at idx=0 still goes to DONE, which guards against an empty table.
  - Undefined: the walk ends in DONE as described above.

## Test plan
- Level 2 table with entries (10,20),(30,40), then FFF; ready tied high; GAP_FRAMES=2:
  - spawn (10,20) is presented 4 cycles after level_start
  - (30,40) follows after 2 frame_ticks
  - done=1 after the terminator fetch
  - rom_addr sequence: 0x20, 0x21, 0x22, 0x23, 0x24.
- Backpressure: hold spawn_ready=0 for 50 cycles.
  - spawn_valid and spawn_x/spawn_y stay stable
  - exactly one transfer occurs when ready rises.
- Full table of 8 entries with no terminator: exactly 8 transfers, then done=1, and rom_addr never exceeds {level,7,1}.
- level_start to level 5 during PRESENT of level 1:
  - valid drops
  - the next spawn comes from address 0x50
  - no transfer is counted for the aborted entry.
- rst asserted during WAIT_GAP: all outputs go to 0 and the block stays IDLE until level_start.
- With ENEMY_SPAWN_LOOP_EN and a 2-entry table: spawns cycle A, B, A, B, and done stays 0. A table whose first x word is FFF gives done=1.
